// File: rtl/qupls_alu_sched_pkg.sv
// -----------------------------------------------------------------------------
// QuplsPkg: shared types for the Qupls meta-ALU issue scheduler.
//   alu_sched_state_t : scheduler FSM states
//   op_kind_t         : decoded op class of a reservation-station request
//   rob_tag_t         : ROB tag type
//   decode_op_kind()  : maps the 2-bit request class onto op_kind_t
// -----------------------------------------------------------------------------
package QuplsPkg;

  localparam int ROB_TAGW = 6;
  typedef logic [ROB_TAGW-1:0] rob_tag_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MUL = 2'd1,
    WAIT_DIV = 2'd2
  } alu_sched_state_t;

  typedef enum logic [1:0] {
    OK_SINGLE = 2'd0,
    OK_MUL    = 2'd1,
    OK_DIV    = 2'd2
  } op_kind_t;

  // Class 3 is reserved and runs as a single-cycle op.
  function automatic op_kind_t decode_op_kind(input logic [1:0] i_kind);
    case (i_kind)
      2'd1:    return OK_MUL;
      2'd2:    return OK_DIV;
      default: return OK_SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/qupls_alu_sched_rr_arbiter.sv
// -----------------------------------------------------------------------------
// qupls_rr_arbiter: round-robin picker. Selects the first asserted request at
// or after the pointer, searching cyclically.
//   i_req  [NREQ]  request lines
//   i_ptr  [PTRW]  highest-priority index this cycle
//   o_gnt  [NREQ]  one-hot selection (all zero when no request)
//   o_idx  [PTRW]  encoded selection
//   o_any          at least one request present
// -----------------------------------------------------------------------------
module qupls_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PTRW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PTRW-1:0] i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PTRW-1:0] o_idx,
  output logic            o_any
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_j = (int'(i_ptr) + i) % NREQ;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = PTRW'(w_j);
      end
    end
  end

endmodule

// File: rtl/qupls_alu_sched.sv
// -----------------------------------------------------------------------------
// qupls_alu_sched: shares one Qupls meta ALU among NREQ reservation stations.
// Round-robin grants single-cycle ops back-to-back; mul/div hold the ALU busy
// until the matching done level arrives, then write back the latched tag.
// Optional macro QUPLS_ALU_SCHED_WDOG_EN adds a wait watchdog (WDOG_CYC).
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   req[NREQ]          request levels, held until granted
//   req_kind[2*NREQ]   op class per requester (0 single, 1 mul, 2 div, 3 single)
//   req_tag[TAGW*NREQ] ROB tag per requester
//   flush              abort in-flight op, block grants this cycle
//   mul_done/div_done  meta ALU completion levels
//   gnt[NREQ]          one-hot grant pulse
//   alu_ld, alu_div    ALU load strobe / div strobe (with gnt)
//   busy               waiting on a mul or div
//   wb_v, wb_tag       result-valid pulse and its tag
//   wdog_exc           watchdog timeout pulse
// -----------------------------------------------------------------------------
import QuplsPkg::*;

module qupls_alu_sched #(
  parameter int NREQ     = 4,
  parameter int TAGW     = 6,
  parameter int WDOG_CYC = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [2*NREQ-1:0]    req_kind,
  input  logic [TAGW*NREQ-1:0] req_tag,
  input  logic                 flush,
  input  logic                 mul_done,
  input  logic                 div_done,
  output logic [NREQ-1:0]      gnt,
  output logic                 alu_ld,
  output logic                 alu_div,
  output logic                 busy,
  output logic                 wb_v,
  output logic [TAGW-1:0]      wb_tag,
  output logic                 wdog_exc
);

  localparam int PTRW = $clog2(NREQ);

  alu_sched_state_t r_state, w_state_nxt;
  logic [PTRW-1:0]  r_rr_ptr;
  logic [NREQ-1:0]  w_arb_gnt;
  logic [PTRW-1:0]  w_arb_idx;
  logic             w_arb_any;
  logic             w_grant;
  op_kind_t         w_kind;
  logic [TAGW-1:0]  w_gnt_tag;
  logic             w_done;
  logic             w_wdog_hit;
  logic             r_first;
  logic [TAGW-1:0]  r_tag;
  logic             r_wb_v, w_wb_v_nxt;
  logic [TAGW-1:0]  r_wb_tag, w_wb_tag_nxt;
  logic             r_wdog, w_wdog_nxt;

  qupls_rr_arbiter #(.NREQ(NREQ), .PTRW(PTRW)) u_arb (
    .i_req (req),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  assign w_grant   = (r_state == IDLE) && !flush && w_arb_any;
  assign w_kind    = decode_op_kind(req_kind[2*w_arb_idx +: 2]);
  assign w_gnt_tag = req_tag[TAGW*w_arb_idx +: TAGW];
  assign w_done    = (r_state == WAIT_MUL) ? mul_done : div_done;

  assign gnt     = w_grant ? w_arb_gnt : '0;
  assign alu_ld  = w_grant;
  assign alu_div = w_grant && (w_kind == OK_DIV);
  assign busy    = (r_state != IDLE);
  // A flush in the writeback cycle kills the result of the op being flushed.
  assign wb_v     = r_wb_v && !flush;
  assign wb_tag   = r_wb_tag;
  assign wdog_exc = r_wdog && !flush;

`ifdef QUPLS_ALU_SCHED_WDOG_EN
  localparam int WCNT_W = ($clog2(WDOG_CYC+1) > 8) ? $clog2(WDOG_CYC+1) : 8;
  logic [WCNT_W-1:0] r_wcnt;

  // Held at zero in IDLE, so the first wait cycle sees a count of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_wcnt <= '0;
    else if (r_state == IDLE)   r_wcnt <= '0;
    else                        r_wcnt <= r_wcnt + 1'b1;
  end

  assign w_wdog_hit = (r_wcnt == WCNT_W'(WDOG_CYC-1));
`else
  logic w_unused_wdog;
  assign w_unused_wdog = (WDOG_CYC != 0);
  assign w_wdog_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wb_v_nxt   = 1'b0;
    w_wb_tag_nxt = r_wb_tag;
    w_wdog_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          case (w_kind)
            OK_MUL:  w_state_nxt = WAIT_MUL;
            OK_DIV:  w_state_nxt = WAIT_DIV;
            default: begin
              w_wb_v_nxt   = 1'b1;
              w_wb_tag_nxt = w_gnt_tag;
            end
          endcase
        end
      end
      WAIT_MUL, WAIT_DIV: begin
        // Done is not trusted in the first wait cycle: it may still be
        // the level left over from the previous op.
        if (flush) begin
          w_state_nxt = IDLE;
        end else if (!r_first && w_done) begin
          w_state_nxt  = IDLE;
          w_wb_v_nxt   = 1'b1;
          w_wb_tag_nxt = r_tag;
        end else if (w_wdog_hit) begin
          w_state_nxt  = IDLE;
          w_wb_v_nxt   = 1'b1;
          w_wb_tag_nxt = r_tag;
          w_wdog_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_first  <= 1'b1;
      r_tag    <= '0;
      r_wb_v   <= 1'b0;
      r_wb_tag <= '0;
      r_wdog   <= 1'b0;
    end else begin
      r_first  <= (r_state == IDLE);
      r_wb_v   <= w_wb_v_nxt;
      r_wb_tag <= w_wb_tag_nxt;
      r_wdog   <= w_wdog_nxt;
      if (w_grant) begin
        r_rr_ptr <= (w_arb_idx == PTRW'(NREQ-1)) ? '0 : w_arb_idx + 1'b1;
        if (w_kind != OK_SINGLE) r_tag <= w_gnt_tag;
      end
    end
  end

endmodule
